axi_lite_mbox_array: RTL and testbench



---
 rtl/axi_lite_mbox_array.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_lite_mbox_array.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mbox_array.sv
// N-channel AXI-Lite mailbox: per-channel DATA FIFO, threshold interrupt (level or pulse) and sticky status.
// One transaction in flight; reads and writes alternate round-robin when both are pending.

package axi_lite_mbox_pkg;
  typedef struct packed { logic [31:0] addr; logic [2:0] prot; } aw_chan_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_chan_t;
  typedef struct packed { logic [1:0] resp; } b_chan_t;
  typedef struct packed { logic [31:0] addr; logic [2:0] prot; } ar_chan_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_lite_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } resp_lite_t;
endpackage

module axi_lite_mbox_array #(
  parameter int unsigned          NumChan   = 4,
  parameter int unsigned          Depth     = 8,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(32'h1040_2000),
  parameter type                  req_lite_t  = axi_lite_mbox_pkg::req_lite_t,
  parameter type                  resp_lite_t = axi_lite_mbox_pkg::resp_lite_t
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  req_lite_t          slv_req_i,
  output resp_lite_t         slv_resp_o,
  output logic [NumChan-1:0] irq_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam int unsigned ChW  = (NumChan > 1) ? $clog2(NumChan) : 1;
  localparam logic [AddrWidth-1:0] WinSize = AddrWidth'(NumChan * 16);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {StIdle, StWrResp, StRdResp} state_e;

  state_e r_state, w_nextState;
  logic   r_lastWasWrite;
  logic [1:0]           r_bResp, r_rResp;
  logic [DataWidth-1:0] r_rData;

  logic [DataWidth-1:0] r_mem   [NumChan][Depth];
  logic [PtrW-1:0]      r_wrPtr [NumChan];
  logic [PtrW-1:0]      r_rdPtr [NumChan];
  logic [CntW-1:0]      r_count [NumChan];
  logic [7:0]           r_thresh[NumChan];
  logic [NumChan-1:0]   r_en, r_mode, r_stat, r_cond, r_irq;

  logic                 w_grantWr, w_grantRd;
  logic [AddrWidth-1:0] w_addr, w_off;
  logic                 w_inRange;
  logic [ChW-1:0]       w_chan;
  logic [1:0]           w_reg;
  logic                 w_full, w_empty, w_push, w_pop;
  logic [1:0]           w_bResp, w_rResp;
  logic [DataWidth-1:0] w_rData;
  logic [NumChan-1:0]   w_cond, w_rise, w_clr;
  logic                 w_unused;

  assign w_unused = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

  // Round-robin: when both are pending, the type not served last goes first.
  assign w_grantWr = (r_state == StIdle) && slv_req_i.aw_valid && slv_req_i.w_valid &&
                     (!slv_req_i.ar_valid || !r_lastWasWrite);
  assign w_grantRd = (r_state == StIdle) && slv_req_i.ar_valid && !w_grantWr;

  assign w_addr    = w_grantWr ? slv_req_i.aw.addr : slv_req_i.ar.addr;
  assign w_off     = w_addr - BaseAddr;
  assign w_inRange = (w_off < WinSize);
  assign w_chan    = w_off[4 +: ChW];
  assign w_reg     = w_off[3:2];
  assign w_full    = (r_count[w_chan] == CntW'(Depth));
  assign w_empty   = (r_count[w_chan] == '0);

  assign w_push = w_grantWr && w_inRange && (w_reg == 2'd0) && (slv_req_i.w.strb == 4'hF) && !w_full;
  assign w_pop  = w_grantRd && w_inRange && (w_reg == 2'd0) && !w_empty;

  always_comb begin
    w_bResp = RespOkay;
    if (!w_inRange) w_bResp = RespDecErr;
    else if ((w_reg == 2'd0) && ((slv_req_i.w.strb != 4'hF) || w_full)) w_bResp = RespSlvErr;
  end

  always_comb begin
    w_rResp = RespOkay;
    w_rData = '0;
    if (!w_inRange) begin
      w_rResp = RespDecErr;
    end else begin
      case (w_reg)
        2'd0: begin
          if (w_empty) w_rResp = RespSlvErr;
          else         w_rData = r_mem[w_chan][r_rdPtr[w_chan]];
        end
        2'd1:    w_rData = DataWidth'({16'(r_count[w_chan]), 14'b0, w_full, w_empty});
        2'd2:    w_rData = DataWidth'({16'b0, r_thresh[w_chan], 5'b0, r_mode[w_chan], 1'b0, r_en[w_chan]});
        default: w_rData = DataWidth'(r_stat[w_chan]);
      endcase
    end
  end

  // A threshold above Depth can never be reached by count, so it yields 0 naturally.
  always_comb begin
    w_cond = '0;
    for (int c = 0; c < NumChan; c++) begin
      if (r_en[c]) begin
        if (r_thresh[c] == 8'd0) w_cond[c] = (r_count[c] != '0);
        else                     w_cond[c] = (32'(r_count[c]) >= 32'(r_thresh[c]));
      end
    end
  end

  assign w_rise = w_cond & ~r_cond;

  always_comb begin
    w_clr = '0;
    if (w_grantWr && w_inRange && (w_reg == 2'd3) && slv_req_i.w.strb[0] && slv_req_i.w.data[0])
      w_clr[w_chan] = 1'b1;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      StIdle: begin
        if (w_grantWr)      w_nextState = StWrResp;
        else if (w_grantRd) w_nextState = StRdResp;
      end
      StWrResp: if (slv_req_i.b_ready) w_nextState = StIdle;
      StRdResp: if (slv_req_i.r_ready) w_nextState = StIdle;
      default:  w_nextState = StIdle;
    endcase
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = w_grantWr;
    slv_resp_o.w_ready  = w_grantWr;
    slv_resp_o.ar_ready = w_grantRd;
    slv_resp_o.b_valid  = (r_state == StWrResp);
    slv_resp_o.b.resp   = r_bResp;
    slv_resp_o.r_valid  = (r_state == StRdResp);
    slv_resp_o.r.data   = r_rData;
    slv_resp_o.r.resp   = r_rResp;
  end

  assign irq_o = r_irq;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[w_chan][r_wrPtr[w_chan]] <= slv_req_i.w.data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= StIdle;
      r_lastWasWrite <= 1'b0;
      r_bResp        <= RespOkay;
      r_rResp        <= RespOkay;
      r_rData        <= '0;
      r_en           <= '0;
      r_mode         <= '0;
      r_stat         <= '0;
      r_cond         <= '0;
      r_irq          <= '0;
      for (int c = 0; c < NumChan; c++) begin
        r_wrPtr[c]  <= '0;
        r_rdPtr[c]  <= '0;
        r_count[c]  <= '0;
        r_thresh[c] <= 8'd1;
      end
    end else begin
      r_state <= w_nextState;
      if (w_grantWr) begin
        r_lastWasWrite <= 1'b1;
        r_bResp        <= w_bResp;
      end
      if (w_grantRd) begin
        r_lastWasWrite <= 1'b0;
        r_rResp        <= w_rResp;
        r_rData        <= w_rData;
      end
      if (w_push) begin
        r_wrPtr[w_chan] <= r_wrPtr[w_chan] + PtrW'(1);
        r_count[w_chan] <= r_count[w_chan] + CntW'(1);
      end
      if (w_pop) begin
        r_rdPtr[w_chan] <= r_rdPtr[w_chan] + PtrW'(1);
        r_count[w_chan] <= r_count[w_chan] - CntW'(1);
      end
      if (w_grantWr && w_inRange && (w_reg == 2'd2)) begin
        if (slv_req_i.w.strb[0]) begin
          r_en[w_chan]   <= slv_req_i.w.data[0];
          r_mode[w_chan] <= slv_req_i.w.data[2];
        end
        if (slv_req_i.w.strb[1]) r_thresh[w_chan] <= slv_req_i.w.data[15:8];
      end
      r_cond <= w_cond;
      for (int c = 0; c < NumChan; c++) r_irq[c] <= r_mode[c] ? w_rise[c] : w_cond[c];
      // Set wins over a simultaneous W1C.
      r_stat <= (r_stat & ~w_clr) | w_rise;
    end
  end

endmodule

// File: tb/tb_axi_lite_mbox_array.sv
// Directed self-checking bench for axi_lite_mbox_array: reset, FIFO fill/drain, level and pulse IRQs,
// arbitration with back-pressure, address decode errors and reset during an outstanding read.

module tb_axi_lite_mbox_array;
  import axi_lite_mbox_pkg::*;

  localparam logic [31:0] Base = 32'h1040_2000;

  logic       clk = 1'b0;
  logic       rst;
  req_lite_t  req;
  resp_lite_t resp;
  logic [3:0] irq;

  int compared   = 0;
  int mismatched = 0;
  int pulseCount = 0;
  logic [3:0] irqAtAccept;

  logic [31:0] rdData;
  logic [1:0]  rdResp, wrResp;
  int          pulseBase;

  axi_lite_mbox_array dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (req),
    .slv_resp_o (resp),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  // Counts channel-0 interrupt high cycles to measure pulse width and number.
  always @(negedge clk) if (irq[0]) pulseCount++;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] bresp);
    int n;
    @(negedge clk);
    req.aw.addr  = addr;
    req.aw_valid = 1'b1;
    req.w.data   = data;
    req.w.strb   = strb;
    req.w_valid  = 1'b1;
    #1;
    n = 0;
    while (!(resp.aw_ready && resp.w_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!(resp.aw_ready && resp.w_ready)) checkOutput("awTimeout", 32'(resp.aw_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    irqAtAccept  = irq;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    req.b_ready  = 1'b1;
    n = 0;
    while (!resp.b_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp.b_valid) checkOutput("bTimeout", 32'(resp.b_valid), 32'd1);
    bresp = resp.b.resp;
    @(posedge clk);
    #1;
    req.b_ready = 1'b0;
  endtask

  task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] rresp);
    int n;
    @(negedge clk);
    req.ar.addr  = addr;
    req.ar_valid = 1'b1;
    #1;
    n = 0;
    while (!resp.ar_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!resp.ar_ready) checkOutput("arTimeout", 32'(resp.ar_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 1'b0;
    req.r_ready  = 1'b1;
    n = 0;
    while (!resp.r_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp.r_valid) checkOutput("rTimeout", 32'(resp.r_valid), 32'd1);
    data  = resp.r.data;
    rresp = resp.r.resp;
    @(posedge clk);
    #1;
    req.r_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    applyReset();

    // T1: reset state and basic register behaviour
    #1;
    checkOutput("t1Irq", 32'(irq), 32'h0);
    checkOutput("t1BValid", 32'(resp.b_valid), 32'h0);
    checkOutput("t1RValid", 32'(resp.r_valid), 32'h0);
    axiRead(Base + 32'h4, rdData, rdResp);
    checkOutput("t1Status", rdData, 32'h0000_0001);
    checkOutput("t1StatusResp", 32'(rdResp), 32'h0);
    axiRead(Base + 32'h8, rdData, rdResp);
    checkOutput("t1IrqCtrl", rdData, 32'h0000_0100);
    axiWrite(Base + 32'h4, 32'hFFFF_FFFF, 4'hF, wrResp);
    checkOutput("t1StatusWrResp", 32'(wrResp), 32'h0);
    axiWrite(Base + 32'h0, 32'h1234_5678, 4'h7, wrResp);
    checkOutput("t1PartialPushResp", 32'(wrResp), 32'h2);
    axiRead(Base + 32'h4, rdData, rdResp);
    checkOutput("t1StatusAfterBad", rdData, 32'h0000_0001);
    axiWrite(Base + 32'h38, 32'h0000_0507, 4'h1, wrResp);
    axiRead(Base + 32'h38, rdData, rdResp);
    checkOutput("t1StrbIrqCtrl", rdData, 32'h0000_0105);

    // T2: fill ch1 to full, overflow, drain in order, underflow
    for (int i = 0; i < 8; i++) begin
      axiWrite(Base + 32'h10, 32'hA0 + 32'(i), 4'hF, wrResp);
      checkOutput($sformatf("t2PushResp%0d", i), 32'(wrResp), 32'h0);
    end
    axiWrite(Base + 32'h10, 32'hA8, 4'hF, wrResp);
    checkOutput("t2OverflowResp", 32'(wrResp), 32'h2);
    axiRead(Base + 32'h14, rdData, rdResp);
    checkOutput("t2StatusFull", rdData, 32'h0008_0002);
    for (int i = 0; i < 8; i++) begin
      axiRead(Base + 32'h10, rdData, rdResp);
      checkOutput($sformatf("t2PopData%0d", i), rdData, 32'hA0 + 32'(i));
      checkOutput($sformatf("t2PopResp%0d", i), 32'(rdResp), 32'h0);
    end
    axiRead(Base + 32'h10, rdData, rdResp);
    checkOutput("t2UnderflowData", rdData, 32'h0);
    checkOutput("t2UnderflowResp", 32'(rdResp), 32'h2);
    axiRead(Base + 32'h14, rdData, rdResp);
    checkOutput("t2StatusEmpty", rdData, 32'h0000_0001);
    // Threshold 255 exceeds Depth: a full FIFO must not raise the interrupt.
    axiWrite(Base + 32'h18, 32'h0000_FF01, 4'h3, wrResp);
    for (int i = 0; i < 8; i++) axiWrite(Base + 32'h10, 32'(i), 4'hF, wrResp);
    repeat (2) @(negedge clk);
    checkOutput("t2BigThreshIrq", 32'(irq[1]), 32'h0);
    axiRead(Base + 32'h1C, rdData, rdResp);
    checkOutput("t2BigThreshStat", rdData, 32'h0);

    // T3: level interrupt on ch2 with threshold 3
    axiWrite(Base + 32'h28, 32'h0000_0301, 4'hF, wrResp);
    axiWrite(Base + 32'h20, 32'h11, 4'hF, wrResp);
    checkOutput("t3IrqAfter1", 32'(irq[2]), 32'h0);
    axiWrite(Base + 32'h20, 32'h22, 4'hF, wrResp);
    checkOutput("t3IrqAfter2", 32'(irq[2]), 32'h0);
    axiWrite(Base + 32'h20, 32'h33, 4'hF, wrResp);
    checkOutput("t3IrqAtAccept3", 32'(irqAtAccept[2]), 32'h0);
    checkOutput("t3IrqAfter3", 32'(irq[2]), 32'h1);
    axiRead(Base + 32'h2C, rdData, rdResp);
    checkOutput("t3StatSet", rdData, 32'h1);
    axiRead(Base + 32'h20, rdData, rdResp);
    checkOutput("t3PopData", rdData, 32'h11);
    checkOutput("t3IrqAfterPop", 32'(irq[2]), 32'h0);
    axiRead(Base + 32'h2C, rdData, rdResp);
    checkOutput("t3StatSticky", rdData, 32'h1);
    axiWrite(Base + 32'h2C, 32'h1, 4'hF, wrResp);
    axiRead(Base + 32'h2C, rdData, rdResp);
    checkOutput("t3StatCleared", rdData, 32'h0);

    // T4: pulse mode on ch0 with threshold 1
    axiWrite(Base + 32'h8, 32'h0000_0105, 4'hF, wrResp);
    repeat (2) @(negedge clk);
    pulseBase = pulseCount;
    axiWrite(Base + 32'h0, 32'h40, 4'hF, wrResp);
    repeat (3) @(negedge clk);
    checkOutput("t4FirstPulse", 32'(pulseCount - pulseBase), 32'd1);
    axiWrite(Base + 32'h0, 32'h41, 4'hF, wrResp);
    repeat (3) @(negedge clk);
    checkOutput("t4NoSecondPulse", 32'(pulseCount - pulseBase), 32'd1);
    axiRead(Base + 32'h0, rdData, rdResp);
    axiRead(Base + 32'h0, rdData, rdResp);
    checkOutput("t4DrainData", rdData, 32'h41);
    axiWrite(Base + 32'h0, 32'h42, 4'hF, wrResp);
    repeat (3) @(negedge clk);
    checkOutput("t4NewPulse", 32'(pulseCount - pulseBase), 32'd2);

    // T5: simultaneous write and read after reset, write first, B held under back-pressure
    applyReset();
    @(negedge clk);
    req.aw.addr  = Base + 32'h30;
    req.aw_valid = 1'b1;
    req.w.data   = 32'h55;
    req.w.strb   = 4'hF;
    req.w_valid  = 1'b1;
    req.ar.addr  = Base + 32'h30;
    req.ar_valid = 1'b1;
    #1;
    checkOutput("t5AwReady", 32'(resp.aw_ready), 32'h1);
    checkOutput("t5ArReadyLow", 32'(resp.ar_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t5BValid%0d", i), 32'(resp.b_valid), 32'h1);
      checkOutput($sformatf("t5BResp%0d", i), 32'(resp.b.resp), 32'h0);
      checkOutput($sformatf("t5ArHeld%0d", i), 32'(resp.ar_ready), 32'h0);
      @(negedge clk);
    end
    req.b_ready = 1'b1;
    @(posedge clk);
    #1;
    req.b_ready = 1'b0;
    checkOutput("t5ArReadyNext", 32'(resp.ar_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 1'b0;
    checkOutput("t5RValid", 32'(resp.r_valid), 32'h1);
    checkOutput("t5RData", resp.r.data, 32'h55);
    checkOutput("t5RResp", 32'(resp.r.resp), 32'h0);
    req.r_ready = 1'b1;
    @(posedge clk);
    #1;
    req.r_ready = 1'b0;

    // T6: decode errors and reset during an outstanding read
    axiRead(Base + 32'h40, rdData, rdResp);
    checkOutput("t6DecErrResp", 32'(rdResp), 32'h3);
    checkOutput("t6DecErrData", rdData, 32'h0);
    axiRead(Base - 32'h4, rdData, rdResp);
    checkOutput("t6BelowBaseResp", 32'(rdResp), 32'h3);
    axiWrite(Base + 32'h40, 32'h99, 4'hF, wrResp);
    checkOutput("t6DecErrWrResp", 32'(wrResp), 32'h3);
    axiWrite(Base + 32'h0, 32'h77, 4'hF, wrResp);
    axiWrite(Base + 32'h0, 32'h78, 4'hF, wrResp);
    @(negedge clk);
    req.ar.addr  = Base + 32'h4;
    req.ar_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 1'b0;
    checkOutput("t6RValidPending", 32'(resp.r_valid), 32'h1);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6RValidAfterReset", 32'(resp.r_valid), 32'h0);
    axiRead(Base + 32'h4, rdData, rdResp);
    checkOutput("t6StatusAfterReset", rdData, 32'h0000_0001);
    axiRead(Base + 32'h8, rdData, rdResp);
    checkOutput("t6IrqCtrlAfterReset", rdData, 32'h0000_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
